// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard sources in, pipeline enables and perf counters out.
// master = pipeline datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_halt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             mem_busy;

  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_halt, ex_mem_read, ex_rt, ex_branch_taken, mem_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, halted,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_halt, ex_mem_read, ex_rt, ex_branch_taken, mem_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, halted,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/sequencing controller; enables are combinational (zero latency).
// Priority: mem wait freeze > taken-branch flush > load-use stall > halt drain; counters saturate.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t           state;
  logic [2:0]       drain_cnt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic load_use;
  logic run_freeze;
  logic run_flush;
  logic run_stall;
  logic run_halt;

  assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  assign run_freeze = (state == RUN) && bus.mem_busy;
  assign run_flush  = (state == RUN) && !bus.mem_busy && bus.ex_branch_taken;
  assign run_stall  = (state == RUN) && !bus.mem_busy && !bus.ex_branch_taken && load_use;
  assign run_halt   = (state == RUN) && !bus.mem_busy && !bus.ex_branch_taken && !load_use &&
                      bus.id_halt;

  always_comb begin
    bus.pc_we        = 1'b0;
    bus.if_id_we     = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b1;
    bus.ex_mem_we    = 1'b1;
    bus.mem_wb_we    = 1'b1;
    if (reset) begin
      // Held reset: keep NOPs flowing into ID/EX while the back end keeps clocking.
      bus.if_id_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (run_freeze) begin
            bus.id_ex_bubble = 1'b0;
            bus.ex_mem_we    = 1'b0;
            bus.mem_wb_we    = 1'b0;
          end else if (run_flush) begin
            bus.pc_we       = 1'b1;
            bus.if_id_we    = 1'b1;
            bus.if_id_flush = 1'b1;
          end else if (run_stall) begin
            bus.id_ex_bubble = 1'b1;
          end else if (run_halt) begin
            // HALT itself proceeds into EX as a no-write op.
            bus.id_ex_bubble = 1'b0;
          end else begin
            bus.pc_we        = 1'b1;
            bus.if_id_we     = 1'b1;
            bus.id_ex_bubble = 1'b0;
          end
        end
        DRAIN: begin
          bus.ex_mem_we = !bus.mem_busy;
          bus.mem_wb_we = !bus.mem_busy;
        end
        default: ;
      endcase
    end
  end

  assign bus.halted       = (state == HALTED);
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= 3'd0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      if ((run_freeze || run_stall) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (run_flush && (flush_q != '1))
        flush_q <= flush_q + 1'b1;

      case (state)
        RUN: begin
          if (run_halt) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (!bus.mem_busy) begin
            if (drain_cnt == 3'd0)
              state <= HALTED;
            else
              drain_cnt <= drain_cnt - 3'd1;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       halt;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       br;
    logic       busy;
    logic [6:0] exp; // {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, halted}
  } vec_t;

  localparam logic [6:0] O_RUN   = 7'b1100110;
  localparam logic [6:0] O_STALL = 7'b0001110;
  localparam logic [6:0] O_FRZ   = 7'b0000000;
  localparam logic [6:0] O_FLUSH = 7'b1111110;
  localparam logic [6:0] O_HALTA = 7'b0000110;
  localparam logic [6:0] O_DRAIN = 7'b0001110;
  localparam logic [6:0] O_DRBSY = 7'b0001000;
  localparam logic [6:0] O_HALTD = 7'b0001111;
  localparam logic [6:0] O_RST   = 7'b0011110;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic halt, input logic mem_read, input logic [4:0] ex_rt,
                              input logic br, input logic busy, input logic [6:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.halt = halt; v.mem_read = mem_read;
    v.ex_rt = ex_rt; v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_bubble,
            bus.ex_mem_we, bus.mem_wb_we, bus.halted};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_uses_rt = v.uses_rt; bus.id_halt = v.halt;
    bus.ex_mem_read = v.mem_read; bus.ex_rt = v.ex_rt;
    bus.ex_branch_taken = v.br; bus.mem_busy = v.busy;
  endtask

  task automatic idle();
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RUN));
  endtask

  // One rising edge; inputs may be changed right after return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    chk("rst_outs", 32'(outs()), 32'(O_RST));
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rst_flush", 32'(bus.flush_count), 32'd0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RUN);
    vecs[1]  = mk(5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, O_STALL);
    vecs[2]  = mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, O_RUN);
    vecs[3]  = mk(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, O_STALL);
    vecs[4]  = mk(5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, O_RUN);
    vecs[5]  = mk(5'd5, 5'd2, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, O_FRZ);
    vecs[6]  = mk(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, O_FLUSH);
    vecs[7]  = mk(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, O_FRZ);
    vecs[8]  = mk(5'd5, 5'd2, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, O_FLUSH);
    vecs[9]  = mk(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, O_HALTA);
    vecs[10] = mk(5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, O_STALL);
    vecs[11] = mk(5'd9, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, O_RUN);

    idle();
    #2;
    do_reset();

    // Combinational table, RUN state, no clock edges in between.
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    idle();
    #1;

    // Load-use: one stall cycle, then the bubble clears the dependency.
    do_reset();
    apply(mk(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, O_STALL));
    #1;
    chk("lu_stall", 32'(outs()), 32'(O_STALL));
    tick();
    bus.ex_mem_read = 1'b0;
    #1;
    chk("lu_after", 32'(outs()), 32'(O_RUN));
    chk("lu_cnt", 32'(bus.stall_cycles), 32'd1);
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, O_RUN));
    #1;
    chk("lu_r0", 32'(outs()), 32'(O_RUN));
    tick();
    chk("lu_r0_cnt", 32'(bus.stall_cycles), 32'd1);

    // Branch beats halt.
    do_reset();
    apply(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, O_FLUSH));
    #1;
    chk("bh_outs", 32'(outs()), 32'(O_FLUSH));
    tick();
    idle();
    #1;
    chk("bh_cnt", 32'(bus.flush_count), 32'd1);
    chk("bh_run", 32'(outs()), 32'(O_RUN));

    // Memory wait over a pending load-use hazard.
    do_reset();
    apply(mk(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, O_FRZ));
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("mw_frz%0d", c), 32'(outs()), 32'(O_FRZ));
      tick();
    end
    bus.mem_busy = 1'b0;
    #1;
    chk("mw_lu", 32'(outs()), 32'(O_STALL));
    tick();
    idle();
    #1;
    chk("mw_run", 32'(outs()), 32'(O_RUN));
    chk("mw_cnt", 32'(bus.stall_cycles), 32'd5);

    // Halt drain, DRAIN_CYCLES=3.
    do_reset();
    bus.id_halt = 1'b1;
    #1;
    chk("hd_accept", 32'(outs()), 32'(O_HALTA));
    tick();
    idle();
    bus.ex_branch_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hd_drain%0d", c), 32'(outs()), 32'(O_DRAIN));
      tick();
    end
    #1;
    chk("hd_halted", 32'(outs()), 32'(O_HALTD));
    tick();
    chk("hd_hold", 32'(outs()), 32'(O_HALTD));
    chk("hd_flush0", 32'(bus.flush_count), 32'd0);
    bus.ex_branch_taken = 1'b0;

    // Halt drain with two memory-wait cycles inside DRAIN.
    do_reset();
    bus.id_halt = 1'b1;
    tick();
    idle();
    #1;
    chk("hb_d0", 32'(outs()), 32'(O_DRAIN));
    tick();
    bus.mem_busy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("hb_busy%0d", c), 32'(outs()), 32'(O_DRBSY));
      tick();
    end
    bus.mem_busy = 1'b0;
    tick();
    #1;
    chk("hb_not_yet", 32'(bus.halted), 32'd0);
    tick();
    #1;
    chk("hb_halted", 32'(outs()), 32'(O_HALTD));

    // Async reset mid-DRAIN with a nonzero counter.
    do_reset();
    bus.ex_branch_taken = 1'b1;
    tick();
    bus.ex_branch_taken = 1'b0;
    bus.id_halt = 1'b1;
    tick();
    idle();
    #1;
    chk("ar_pre_cnt", 32'(bus.flush_count), 32'd1);
    chk("ar_pre", 32'(outs()), 32'(O_DRAIN));
    #1;
    reset = 1'b1;
    #1;
    chk("ar_outs", 32'(outs()), 32'(O_RST));
    chk("ar_flush", 32'(bus.flush_count), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("ar_run", 32'(outs()), 32'(O_RUN));
    tick();
    chk("ar_still_run", 32'(outs()), 32'(O_RUN));

    // Flush counter saturation at 2^CW-1.
    do_reset();
    bus.ex_branch_taken = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    chk("sat14", 32'(bus.flush_count), 32'd14);
    for (int c = 0; c < 6; c++) tick();
    chk("sat20", 32'(bus.flush_count), 32'd15);
    tick();
    chk("sat21", 32'(bus.flush_count), 32'd15);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
